ysyx_22040088_muldiv: RTL and testbench
=======================================

Name: ysyx_22040088_muldiv

Overview:
- Parametrised, iterative RV M-extension execution unit: MUL/MULH/MULHSU/MULHU, DIV/DIVU/REM/REMU, plus the RV64 word forms (MULW, DIVW, DIVUW, REMW, REMUW).
- Sits beside the single-cycle ALU in EXU. The control unit steers mul/div/rem instructions here instead of the ALU. The core stalls on in_ready/out_valid.
- Uses a 1 bit/cycle shift-add multiplier and a restoring divider.

Parameters:
- XLEN, 64, datapath width. Legal values are 32 and 64. When XLEN=32 the word input is ignored and treated as 0.

Ports:
- clk  in  1  core clock
- rst_n  in  1  reset, asynchronous, active-low
- flush  in  1  synchronous abort of any in-flight operation
- in_valid  in  1  request valid
- in_ready  out  1  unit can accept a request; high only in IDLE
- funct3  in  3  000 mul, 001 mulh, 010 mulhsu, 011 mulhu, 100 div, 101 divu, 110 rem, 111 remu
- word  in  1  32-bit word form (opcode 0111011)
- src1  in  XLEN  rs1 value
- src2  in  XLEN  rs2 value
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts the result
- result  out  XLEN  result value
- busy  out  1  high in CALC or DONE

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=IDLE, out_valid=0, result=0, busy=0, counter=0, in_ready=1.
  - Reset asserted mid-operation discards the operation with no output.
- States and transitions:
  - IDLE→CALC on in_valid && in_ready && !flush. funct3, word and the operands are latched on that edge.
  - CALC runs for N cycles, where N=XLEN, or N=32 if word. Then CALC→DONE.
  - DONE holds out_valid=1 and a stable result until out_ready. DONE→IDLE on the out_valid && out_ready edge.
- Latency and throughput:
  - Handshake in cycle 0. CALC occupies cycles 1..N. out_valid is first high in cycle N+1.
  - There is no overlap: the next request is accepted at the earliest in the cycle after the result handshake.
  - in_ready is combinational from state only. It does not depend on in_valid.
- Fast path: divide-by-zero and signed overflow skip CALC and go IDLE→DONE, so out_valid is high in cycle 1.
  - Divide by zero: quotient = all ones, remainder = dividend (width-adjusted).
  - Signed overflow (div/rem with dividend=-2^(W-1), divisor=-1): quotient = dividend, remainder = 0.
  - The fast path applies equally to the word forms at W=32.
- Multiply:
  - Operands are extended to 2W bits: sign-extended for signed, zero-extended for unsigned. mulhsu uses signed src1 and unsigned src2.
  - mul returns product[W-1:0]. mulh, mulhsu and mulhu return product[2W-1:W].
- Divide:
  - Signed operands are converted to magnitudes. An unsigned restoring division runs for W iterations.
  - Quotient sign = sign1 XOR sign2. Remainder sign = sign of the dividend.
- Word mode:
  - Operands are src[31:0], sign- or zero-extended per op.
  - The 32-bit result is sign-extended to XLEN. This includes divuw and remuw.
  - word with funct3 001–011 executes as MULW.
- flush:
  - In CALC or DONE, the next edge goes to IDLE, out_valid=0, and the result is dropped.
  - flush in IDLE together with in_valid: the request is not accepted.
  - flush has priority over out_ready in the same cycle; no result is delivered.
- Backpressure: while out_valid && !out_ready, result and out_valid stay constant and in_ready=0.
- Overlapping events:
  - A result handshake and a new in_valid in the same cycle: the new request is not accepted that cycle, because in_ready=0 in DONE.
  - When counter=1 in CALC, the next edge moves to DONE. The counter never wraps.

Test Plan:
- Multiply: mul with XLEN=64, src1=3, src2=0xFFFFFFFFFFFFFFFB → result=0xFFFFFFFFFFFFFFF1. out_valid is first high 65 cycles after the handshake.
- High multiply:
  - mulhu with both operands all-ones → 0xFFFFFFFFFFFFFFFE.
  - mulh with the same operands → 0.
  - mulhsu with src1=-1, src2=2 → 0xFFFFFFFFFFFFFFFF.
- Divide special cases:
  - div with src2=0, src1=7 → 0xFFFF…FF; rem → 7; out_valid in cycle 1.
  - div with 0x8000000000000000 / -1 → 0x8000000000000000; rem → 0.
- Word forms:
  - divw with src1=0x00000000FFFFFFF9 (-7), src2=2 → 0xFFFFFFFFFFFFFFFD; remw → 0xFFFFFFFFFFFFFFFF.
  - divuw with src1=0xFFFFFFFF, src2=1 → 0xFFFFFFFFFFFFFFFF.
  - All word forms complete after 32 CALC cycles.
- Flush and reset:
  - flush at CALC cycle 10 → next cycle IDLE, in_ready=1, out_valid is never high; the next op gives its correct result.
  - rst_n dropped mid-CALC → outputs immediately return to their reset values.
- Backpressure: out_ready held low for 5 cycles in DONE with in_valid=1 → result stable, in_ready=0, no accept. After the handshake, the next request is accepted one cycle later.

Source files
------------

// File: rtl/ysyx_22040088_muldiv_if.sv
// Request/response bundle between the EXU control path and the mul/div unit.
// The core side (master) issues operations and accepts results; the unit side
// (slave) reports readiness, busy status and the result.
interface ysyx_22040088_muldiv_if #(
    parameter int XLEN = 64
);
    logic            flush;
    logic            in_valid;
    logic            in_ready;
    logic [2:0]      funct3;
    logic            word;
    logic [XLEN-1:0] src1;
    logic [XLEN-1:0] src2;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] result;
    logic            busy;

    modport master (
        output flush, in_valid, funct3, word, src1, src2, out_ready,
        input  in_ready, out_valid, result, busy
    );

    modport slave (
        input  flush, in_valid, funct3, word, src1, src2, out_ready,
        output in_ready, out_valid, result, busy
    );
endinterface

// File: rtl/ysyx_22040088_muldiv.sv
// Iterative RV M-extension unit: 1 bit/cycle shift-add multiplier and
// restoring divider working on operand magnitudes, with the sign applied
// when the last iteration completes. Word forms run 32 iterations and
// sign-extend their 32-bit result. Divide-by-zero and signed overflow
// bypass the iteration and go straight to DONE.
module ysyx_22040088_muldiv #(
    parameter int XLEN = 64
) (
    input logic                   clk,
    input logic                   rst_n,
    ysyx_22040088_muldiv_if.slave bus
);
    localparam int CW = $clog2(XLEN) + 1;
    localparam int W2 = 2 * XLEN;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [XLEN-1:0] res_q, res_d;
    logic [2:0]      op_q, op_d;
    logic            word_q, word_d;
    logic            neg_q, neg_d;
    logic            negr_q, negr_d;
    // mul: product / multiplicand / multiplier; div: remainder / divisor / dividend+quotient
    logic [W2-1:0]   acc_q, acc_d;
    logic [W2-1:0]   opa_q, opa_d;
    logic [XLEN-1:0] opb_q, opb_d;

    logic            accept;
    logic            word_in, is_div, s1, s2, sgn1, sgn2, div0, ovf, fast;
    logic [2:0]      op_in;
    logic [XLEN-1:0] ext1, ext2, mag1, mag2, min_v, fast_res;

    logic [W2-1:0]   mul_acc, mul_ps;
    logic [XLEN:0]   rtry;
    logic            ge;
    logic [XLEN-1:0] rnew, quo, mul_r, div_r, fin_res;

    function automatic logic [XLEN-1:0] sext32(input logic [31:0] x);
        return XLEN'($signed(x));
    endfunction

    // Word results are the low 32 bits sign-extended, unsigned forms included.
    function automatic logic [XLEN-1:0] fmt(input logic [XLEN-1:0] x, input logic w);
        return w ? sext32(x[31:0]) : x;
    endfunction

    assign accept = (state_q == S_IDLE) && bus.in_valid && !bus.flush;

    // Decode the incoming request: operand extension, magnitudes and fast-path results.
    always_comb begin
        word_in = (XLEN == 64) && bus.word;
        is_div  = bus.funct3[2];
        op_in   = (word_in && !is_div) ? 3'b000 : bus.funct3;
        s1      = is_div ? !op_in[0] : (op_in[1:0] == 2'b01 || op_in[1:0] == 2'b10);
        s2      = is_div ? !op_in[0] : (op_in[1:0] == 2'b01);
        ext1    = word_in ? (s1 ? sext32(bus.src1[31:0]) : XLEN'(bus.src1[31:0])) : bus.src1;
        ext2    = word_in ? (s2 ? sext32(bus.src2[31:0]) : XLEN'(bus.src2[31:0])) : bus.src2;
        sgn1    = s1 && ext1[XLEN-1];
        sgn2    = s2 && ext2[XLEN-1];
        mag1    = sgn1 ? -ext1 : ext1;
        mag2    = sgn2 ? -ext2 : ext2;
        min_v   = word_in ? sext32(32'h8000_0000) : {1'b1, {(XLEN-1){1'b0}}};
        div0    = is_div && (ext2 == '0);
        ovf     = is_div && s1 && (ext1 == min_v) && (&ext2);
        fast    = div0 || ovf;
        if (div0) begin
            fast_res = op_in[1] ? fmt(ext1, word_in) : '1;
        end else begin
            fast_res = op_in[1] ? '0 : fmt(ext1, word_in);
        end
    end

    // One multiply or divide iteration, plus the signed/formatted final result.
    always_comb begin
        mul_acc = acc_q + (opb_q[0] ? opa_q : '0);
        rtry    = {acc_q[XLEN-1:0], opb_q[XLEN-1]};
        ge      = rtry >= {1'b0, opa_q[XLEN-1:0]};
        rnew    = ge ? XLEN'(rtry - {1'b0, opa_q[XLEN-1:0]}) : rtry[XLEN-1:0];
        quo     = {opb_q[XLEN-2:0], ge};
        mul_ps  = neg_q ? -mul_acc : mul_acc;
        mul_r   = (op_q[1:0] == 2'b00) ? mul_ps[XLEN-1:0] : mul_ps[W2-1:XLEN];
        div_r   = op_q[1] ? (negr_q ? -rnew : rnew) : (neg_q ? -quo : quo);
        fin_res = fmt(op_q[2] ? div_r : mul_r, word_q);
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (accept) state_d = fast ? S_DONE : S_CALC;
            S_CALC: begin
                if (bus.flush) state_d = S_IDLE;
                else if (cnt_q == CW'(1)) state_d = S_DONE;
            end
            S_DONE: if (bus.flush || bus.out_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Handshake outputs depend on state only.
    always_comb begin
        bus.in_ready  = (state_q == S_IDLE);
        bus.out_valid = (state_q == S_DONE);
        bus.busy      = (state_q != S_IDLE);
        bus.result    = res_q;
    end

    // Datapath next values: latch on accept, iterate in CALC, capture the result on the last step.
    always_comb begin
        acc_d  = acc_q;
        opa_d  = opa_q;
        opb_d  = opb_q;
        op_d   = op_q;
        word_d = word_q;
        neg_d  = neg_q;
        negr_d = negr_q;
        cnt_d  = cnt_q;
        res_d  = res_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    op_d   = op_in;
                    word_d = word_in;
                    neg_d  = sgn1 ^ sgn2;
                    negr_d = sgn1;
                    acc_d  = '0;
                    if (is_div) begin
                        opa_d = W2'(mag2);
                        // Left-align a word dividend so its MSB is shifted out first.
                        opb_d = word_in ? (mag1 << (XLEN - 32)) : mag1;
                    end else begin
                        opa_d = W2'(mag1);
                        opb_d = mag2;
                    end
                    if (fast) begin
                        res_d = fast_res;
                        cnt_d = '0;
                    end else begin
                        cnt_d = word_in ? CW'(32) : CW'(XLEN);
                    end
                end
            end
            S_CALC: begin
                if (bus.flush) begin
                    cnt_d = '0;
                end else begin
                    if (op_q[2]) begin
                        acc_d = W2'(rnew);
                        opb_d = quo;
                    end else begin
                        acc_d = mul_acc;
                        opa_d = opa_q << 1;
                        opb_d = opb_q >> 1;
                    end
                    cnt_d = cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) res_d = fin_res;
                end
            end
            default: ;
        endcase
    end

    // Control state and the visible result, cleared by the asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
        end
    end

    // Working registers; only meaningful after an accept, so no reset.
    always_ff @(posedge clk) begin
        acc_q  <= acc_d;
        opa_q  <= opa_d;
        opb_q  <= opb_d;
        op_q   <= op_d;
        word_q <= word_d;
        neg_q  <= neg_d;
        negr_q <= negr_d;
    end
endmodule

// File: tb/tb_ysyx_22040088_muldiv.sv
// Scoreboard bench for ysyx_22040088_muldiv (XLEN=64): directed operations
// push their expected result and latency; a negedge monitor checks them
// when the unit presents out_valid.
module tb_ysyx_22040088_muldiv;
    localparam int XLEN = 64;

    typedef struct {
        logic [63:0] res;
        int          lat;
        int          acc_cyc;
    } exp_t;

    logic clk;
    logic rst_n;
    int   cyc;
    int   n_total;
    int   n_pass;
    bit   head_seen;
    exp_t exp_q[$];

    ysyx_22040088_muldiv_if #(.XLEN(XLEN)) bus ();

    ysyx_22040088_muldiv #(.XLEN(XLEN)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Monitor: latency on first out_valid, result on the out_valid && out_ready handshake.
    always @(negedge clk) begin
        if (bus.out_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_out_valid", 64'(bus.out_valid), 64'd0);
            end else begin
                if (!head_seen) begin
                    head_seen = 1'b1;
                    chk("latency", 64'(cyc - exp_q[0].acc_cyc), 64'(exp_q[0].lat));
                end
                if (bus.out_ready) begin
                    chk("result", bus.result, exp_q[0].res);
                    void'(exp_q.pop_front());
                    head_seen = 1'b0;
                end
            end
        end
    end

    task automatic send(input logic [2:0] f3, input logic w, input logic [63:0] a,
                        input logic [63:0] b, input logic [63:0] exp, input int lat,
                        output int acc_at);
        bit   got;
        exp_t e;
        got    = 1'b0;
        acc_at = -1;
        bus.in_valid = 1'b1;
        bus.funct3   = f3;
        bus.word     = w;
        bus.src1     = a;
        bus.src2     = b;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                got = 1'b1;
                break;
            end
        end
        if (got) begin
            e.res = exp;
            e.lat = lat;
            e.acc_cyc = cyc;
            exp_q.push_back(e);
            acc_at = cyc;
        end else begin
            chk("accept_timeout", 64'(bus.in_ready), 64'd1);
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            chk("drain_timeout", 64'(exp_q.size()), 64'd0);
            exp_q.delete();
            head_seen = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic op(input logic [2:0] f3, input logic w, input logic [63:0] a,
                      input logic [63:0] b, input logic [63:0] exp, input int lat);
        int acc_at;
        send(f3, w, a, b, exp, lat, acc_at);
        wait_idle();
    endtask

    initial begin
        int acc_at;
        int h;
        int n;
        int vcnt;
        cyc = 0;
        n_total = 0;
        n_pass = 0;
        head_seen = 1'b0;
        rst_n = 1'b0;
        bus.flush = 1'b0;
        bus.in_valid = 1'b0;
        bus.funct3 = 3'b000;
        bus.word = 1'b0;
        bus.src1 = '0;
        bus.src2 = '0;
        bus.out_ready = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_result", bus.result, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // multiplies
        op(3'b000, 1'b0, 64'd3, 64'hFFFF_FFFF_FFFF_FFFB, 64'hFFFF_FFFF_FFFF_FFF1, 65);
        op(3'b011, 1'b0, '1, '1, 64'hFFFF_FFFF_FFFF_FFFE, 65);
        op(3'b001, 1'b0, '1, '1, 64'd0, 65);
        op(3'b010, 1'b0, '1, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 65);

        // divide fast paths
        op(3'b100, 1'b0, 64'd7, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1);
        op(3'b110, 1'b0, 64'd7, 64'd0, 64'd7, 1);
        op(3'b100, 1'b0, 64'h8000_0000_0000_0000, '1, 64'h8000_0000_0000_0000, 1);
        op(3'b110, 1'b0, 64'h8000_0000_0000_0000, '1, 64'd0, 1);

        // iterative divides
        op(3'b100, 1'b0, 64'hFFFF_FFFF_FFFF_FF9C, 64'd7, 64'hFFFF_FFFF_FFFF_FFF2, 65);
        op(3'b110, 1'b0, 64'hFFFF_FFFF_FFFF_FF9C, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 65);
        op(3'b101, 1'b0, '1, 64'd2, 64'h7FFF_FFFF_FFFF_FFFF, 65);
        op(3'b111, 1'b0, 64'd100, 64'd7, 64'd2, 65);

        // word forms
        op(3'b100, 1'b1, 64'h0000_0000_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 33);
        op(3'b110, 1'b1, 64'h0000_0000_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 33);
        op(3'b101, 1'b1, 64'h0000_0000_FFFF_FFFF, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 33);
        op(3'b000, 1'b1, 64'h1234_5678_0001_0000, 64'h0000_0000_0000_8000, 64'hFFFF_FFFF_8000_0000, 33);
        op(3'b001, 1'b1, 64'h0000_0000_0001_0000, 64'hABCD_0000_0000_8000, 64'hFFFF_FFFF_8000_0000, 33);
        op(3'b101, 1'b1, 64'h0000_0000_8000_0001, 64'h0000_0001_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1);
        op(3'b111, 1'b1, 64'h0000_0000_8000_0001, 64'h0000_0001_0000_0000, 64'hFFFF_FFFF_8000_0001, 1);
        op(3'b100, 1'b1, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, 64'hFFFF_FFFF_8000_0000, 1);

        // flush together with in_valid in IDLE: not accepted
        bus.in_valid = 1'b1;
        bus.flush = 1'b1;
        bus.funct3 = 3'b000;
        bus.word = 1'b0;
        @(posedge clk);
        #1;
        chk("idle_flush_busy", 64'(bus.busy), 64'd0);
        chk("idle_flush_in_ready", 64'(bus.in_ready), 64'd1);
        bus.in_valid = 1'b0;
        bus.flush = 1'b0;

        // flush at CALC cycle 10
        send(3'b100, 1'b0, 64'd1000, 64'd3, 64'd333, 65, acc_at);
        repeat (9) @(posedge clk);
        #1;
        bus.flush = 1'b1;
        @(posedge clk);
        #1;
        bus.flush = 1'b0;
        exp_q.delete();
        head_seen = 1'b0;
        chk("flush_in_ready", 64'(bus.in_ready), 64'd1);
        chk("flush_out_valid", 64'(bus.out_valid), 64'd0);
        chk("flush_busy", 64'(bus.busy), 64'd0);
        vcnt = 0;
        repeat (70) begin
            @(negedge clk);
            if (bus.out_valid) vcnt++;
        end
        chk("flush_no_valid", 64'(vcnt), 64'd0);
        @(posedge clk);
        #1;
        op(3'b100, 1'b0, 64'd1000, 64'd3, 64'd333, 65);

        // reset mid-CALC
        send(3'b000, 1'b0, 64'd5, 64'd6, 64'd30, 65, acc_at);
        repeat (20) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("midrst_result", bus.result, 64'd0);
        chk("midrst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("midrst_busy", 64'(bus.busy), 64'd0);
        chk("midrst_in_ready", 64'(bus.in_ready), 64'd1);
        exp_q.delete();
        head_seen = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        op(3'b000, 1'b0, 64'd5, 64'd6, 64'd30, 65);

        // backpressure with a pending request
        bus.out_ready = 1'b0;
        send(3'b100, 1'b0, 64'd100, 64'd7, 64'd14, 65, acc_at);
        n = 0;
        while (!bus.out_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b1;
        bus.funct3 = 3'b101;
        bus.word = 1'b0;
        bus.src1 = 64'd100;
        bus.src2 = 64'd3;
        repeat (5) begin
            @(negedge clk);
            chk("bp_result", bus.result, 64'd14);
            chk("bp_in_ready", 64'(bus.in_ready), 64'd0);
            chk("bp_out_valid", 64'(bus.out_valid), 64'd1);
            @(posedge clk);
            #1;
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        h = cyc;
        send(3'b101, 1'b0, 64'd100, 64'd3, 64'd33, 65, acc_at);
        chk("bp_accept_delay", 64'(acc_at - h), 64'd1);
        wait_idle();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d passed so far", n_pass, n_total);
        $fatal(1);
    end
endmodule
